// File: rtl/sha_round_seq_pkg.sv
// Shared types and default constants for the SHA round sequencer.
package sha_seq_pkg;

  localparam int unsigned CNT_W_DEF     = 7;
  localparam int unsigned ROUNDS_M0_DEF = 64;
  localparam int unsigned ROUNDS_M1_DEF = 80;
  localparam int unsigned MSG_WORDS_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/sha_round_seq_if.sv
// Control/status bundle between the host FSM, the round sequencer and the datapath.
interface sha_round_seq_if #(
  parameter int unsigned CNT_W = sha_seq_pkg::CNT_W_DEF
) ();

  logic             start;
  logic             mode;
  logic             adv;
  logic             abort;
  logic             busy;
  logic             mode_q;
  logic [CNT_W-1:0] round;
  logic             round_first;
  logic             round_last;
  logic             msg_sel;
  logic             load_init;
  logic             round_en;
  logic             hash_upd;
  logic             done;

  modport master (
    output start, mode, adv, abort,
    input  busy, mode_q, round, round_first, round_last, msg_sel,
           load_init, round_en, hash_upd, done
  );

  modport slave (
    input  start, mode, adv, abort,
    output busy, mode_q, round, round_first, round_last, msg_sel,
           load_init, round_en, hash_upd, done
  );

endinterface

// File: rtl/sha_round_seq_cnt.sv
// Round index counter with clear/enable and terminal-count compare against a runtime limit.
module sha_round_cnt #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt_c,
  output logic             tc_c,
  output logic             tc_nxt_c
);

  // Clear has priority so leaving RUN always parks the index at zero.
  always_comb begin
    cnt_nxt_c = cnt;
    if (clr) begin
      cnt_nxt_c = '0;
    end else if (en) begin
      cnt_nxt_c = cnt + CNT_W'(1);
    end
  end

  assign tc_c     = (cnt == limit);
  assign tc_nxt_c = (cnt_nxt_c == limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt_c;
    end
  end

endmodule

// File: rtl/sha_round_seq.sv
// Start/done handshaked round sequencer: drives round index, flags and datapath strobes.
module sha_round_seq
  import sha_seq_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned ROUNDS_M0 = ROUNDS_M0_DEF,
  parameter int unsigned ROUNDS_M1 = ROUNDS_M1_DEF,
  parameter int unsigned MSG_WORDS = MSG_WORDS_DEF
) (
  input logic           clk,
  input logic           rst,
  sha_round_seq_if.slave bus
);

  if ((64'(ROUNDS_M1) > (64'd1 << CNT_W)) || (64'(ROUNDS_M0) > (64'd1 << CNT_W))) begin : g_cnt_w_chk
    $error("sha_round_seq: CNT_W too narrow for the configured round counts");
  end

  state_e           state;
  state_e           state_nxt;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] round_nxt;
  logic             tc;
  logic             tc_nxt;

  assign limit = bus.mode_q ? CNT_W'(ROUNDS_M1 - 1) : CNT_W'(ROUNDS_M0 - 1);

  sha_round_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .limit     (limit),
    .cnt       (bus.round),
    .cnt_nxt_c (round_nxt),
    .tc_c      (tc),
    .tc_nxt_c  (tc_nxt)
  );

  // Next-state and counter control; abort overrides every transition, including start in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN: begin
        if (bus.adv) begin
          if (tc) state_nxt = FINAL;
          else    cnt_en    = 1'b1;
        end
      end
      FINAL:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort) state_nxt = IDLE;
    if (state == IDLE || state_nxt == IDLE) begin
      cnt_clr = 1'b1;
      cnt_en  = 1'b0;
    end
  end

  // Flags and strobes are registered from the next state so they line up with the registered index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.mode_q      <= 1'b0;
      bus.busy        <= 1'b0;
      bus.load_init   <= 1'b0;
      bus.round_first <= 1'b0;
      bus.round_last  <= 1'b0;
      bus.msg_sel     <= 1'b0;
      bus.hash_upd    <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == LOAD) bus.mode_q <= bus.mode;
      bus.busy        <= (state_nxt != IDLE);
      bus.load_init   <= (state_nxt == LOAD);
      bus.round_first <= (state_nxt == RUN) && (round_nxt == '0);
      bus.round_last  <= (state_nxt == RUN) && tc_nxt;
      bus.msg_sel     <= (state_nxt == RUN) && (32'(round_nxt) < MSG_WORDS);
      bus.hash_upd    <= (state_nxt == FINAL);
      bus.done        <= (state_nxt == DONE);
    end
  end

  // Must follow adv within the same cycle, so it is decoded rather than registered.
  assign bus.round_en = (state == RUN) && bus.adv;

endmodule

// File: tb/tb_sha_round_seq.sv
// Scoreboard bench for sha_round_seq: directed blocks, stall, abort, held start and reset.
module tb_sha_round_seq;
  import sha_seq_pkg::*;

  localparam int unsigned CW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  sha_round_seq_if #(.CNT_W(CW)) bus ();

  sha_round_seq #(
    .CNT_W     (CW),
    .ROUNDS_M0 (64),
    .ROUNDS_M1 (80),
    .MSG_WORDS (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t_load;
    int t_last;
    int t_hash;
    int t_done;
    bit mode;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  int   exp_round = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int rounds_of(input bit m);
    return m ? 80 : 64;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  function automatic void push_exp(input int t, input bit m, input int stall);
    int r;
    r = rounds_of(m);
    sb.push_back('{t + 1, t + 1 + r + stall, t + 2 + r + stall, t + 3 + r + stall, m});
  endfunction

  task automatic issue(input bit m, input int stall, output int t);
    t = cyc;
    push_exp(t, m, stall);
    bus.mode  = m;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   int'(bus.busy), 0);
    chk({tag, "_round"},  int'(bus.round), 0);
    chk({tag, "_mode_q"}, int'(bus.mode_q), 0);
    chk({tag, "_first"},  int'(bus.round_first), 0);
    chk({tag, "_last"},   int'(bus.round_last), 0);
    chk({tag, "_msg"},    int'(bus.msg_sel), 0);
    chk({tag, "_load"},   int'(bus.load_init), 0);
    chk({tag, "_ren"},    int'(bus.round_en), 0);
    chk({tag, "_hash"},   int'(bus.hash_upd), 0);
    chk({tag, "_done"},   int'(bus.done), 0);
  endtask

  // Monitor: compares every cycle's outputs against the head of the expectation queue.
  always @(negedge clk) begin : mon
    int exp_busy;
    bit run_c;
    int r;
    if (mon_en) begin
      exp_busy = 0;
      if (sb.size() > 0) exp_busy = int'(cyc >= sb[0].t_load && cyc <= sb[0].t_done);
      chk("busy", int'(bus.busy), exp_busy);
      run_c = bus.busy && !bus.load_init && !bus.hash_upd && !bus.done;
      if (bus.load_init) begin
        if (sb.size() == 0) chk("load_unexpected", 1, 0);
        else                chk("load_cycle", cyc, sb[0].t_load);
        exp_round = 0;
      end
      if (run_c && sb.size() > 0) begin
        r = rounds_of(sb[0].mode);
        chk("round",       int'(bus.round), exp_round);
        chk("round_first", int'(bus.round_first), int'(exp_round == 0));
        chk("round_last",  int'(bus.round_last), int'(exp_round == r - 1));
        chk("msg_sel",     int'(bus.msg_sel), int'(exp_round < 16));
        chk("round_en",    int'(bus.round_en), int'(bus.adv));
        if (bus.round_last && bus.adv) chk("last_cycle", cyc, sb[0].t_last);
        if (bus.adv) exp_round++;
      end else begin
        chk("round_en_idle", int'(bus.round_en), 0);
      end
      if (bus.hash_upd) begin
        if (sb.size() == 0) chk("hash_unexpected", 1, 0);
        else                chk("hash_cycle", cyc, sb[0].t_hash);
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          chk("done_cycle", cyc, sb[0].t_done);
          chk("mode_q", int'(bus.mode_q), int'(sb[0].mode));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    int t2;
    int td2;
    bit m1;
    bit m2;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.adv   = 1'b1;
    bus.abort = 1'b0;

    rst = 1'b1;
    repeat (2) step();
    chk_all_zero("reset");
    rst    = 1'b0;
    mon_en = 1'b1;
    step();

    // abort in IDLE blocks start
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_idle_busy", int'(bus.busy), 0);
    step();

    issue(1'b0, 0, t);
    wait_until(t + 3 + 64 + 1);
    chk("m0_retired", sb.size(), 0);

    issue(1'b1, 0, t);
    wait_until(t + 3 + 80 + 1);
    chk("m1_retired", sb.size(), 0);

    // three-cycle stall at round 20
    issue(1'b0, 3, t);
    wait_until(t + 22);
    bus.adv = 1'b0;
    repeat (3) step();
    chk("stall_hold", int'(bus.round), 20);
    bus.adv = 1'b1;
    wait_until(t + 71);
    chk("stall_retired", sb.size(), 0);

    // abort at round 30, then a fresh block
    issue(1'b0, 0, t);
    wait_until(t + 32);
    chk("abort_pre_round", int'(bus.round), 30);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    void'(sb.pop_back());
    chk("abort_busy",  int'(bus.busy), 0);
    chk("abort_round", int'(bus.round), 0);
    repeat (6) step();
    issue(1'b1, 0, t);
    wait_until(t + 84);
    chk("post_abort_retired", sb.size(), 0);

    // start held high with mode toggling every cycle
    t  = cyc;
    m1 = cyc[0];
    t2 = t + 4 + rounds_of(m1);
    m2 = t2[0];
    push_exp(t, m1, 0);
    push_exp(t2, m2, 0);
    td2 = t2 + 3 + rounds_of(m2);
    bus.mode  = cyc[0];
    bus.start = 1'b1;
    while (cyc < td2 + 1) begin
      step();
      bus.mode = cyc[0];
      if (cyc >= t2 + 1) bus.start = 1'b0;
    end
    chk("held_retired", sb.size(), 0);
    chk("held_idle_busy", int'(bus.busy), 0);
    step();

    // synchronous reset at round 40
    issue(1'b1, 0, t);
    wait_until(t + 42);
    chk("rst_pre_round", int'(bus.round), 40);
    rst = 1'b1;
    step();
    void'(sb.pop_back());
    chk_all_zero("midrst");
    rst = 1'b0;
    repeat (90) step();
    chk("rst_retired", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha_round_seq.md
Name: sha_round_seq

Overview:
- Parametrised round sequencer for the SHA compression core; generalises the free-running round counter into a start/done-handshaked controller.
- Covers two configurable round counts: mode 0 = SHA-224/256, 64 rounds; mode 1 = SHA-384/512, 80 rounds.
- Sits between the block-level host FSM and the datapath (message schedule, working-variable registers, final hash adder).
- Provides the round index, first/last flags, schedule-source select, init-load and hash-update strobes, with stall and abort support.

Parameters:
- CNT_W, 7, width of round index; elaboration error if ROUNDS_M1-1 > 2^CNT_W-1.
- ROUNDS_M0, 64, rounds per block in mode 0.
- ROUNDS_M1, 80, rounds per block in mode 1.
- MSG_WORDS, 16, rounds that take W directly from the message block.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a block; sampled only in IDLE.
- mode  in  1  round-count select; captured on accepted start.
- adv  in  1  round advance enable in RUN; 0 = stall.
- abort  in  1  return to IDLE next cycle; no done.
- busy  out  1  high in every state except IDLE.
- mode_q  out  1  latched mode.
- round  out  CNT_W  current round index.
- round_first  out  1  RUN and round==0.
- round_last  out  1  RUN and round==ROUNDS(mode_q)-1.
- msg_sel  out  1  RUN and round<MSG_WORDS; W from message, else from schedule.
- load_init  out  1  one-cycle strobe in LOAD; datapath loads working vars from H.
- round_en  out  1  RUN and adv; datapath performs a round this cycle.
- hash_upd  out  1  one-cycle strobe in FINAL; H += working vars.
- done  out  1  one-cycle pulse in DONE.

Behaviour:
- Decision: clk / rst. Reset is synchronous, active-high, and there is a single clock.
- Reset values: state IDLE, round 0, mode_q 0. All outputs are 0.
- FSM states: IDLE, LOAD, RUN, FINAL, DONE.
- IDLE: if start && !abort, capture mode into mode_q, clear round, go to LOAD. Otherwise stay.
- LOAD: load_init=1 for one cycle, then go to RUN. adv is ignored in this state.
- RUN, adv=1 and !round_last: round increments by 1.
- RUN, adv=1 and round_last: go to FINAL; round holds its value.
- RUN, adv=0: round and state hold. round_en=0; flags stay valid for the held round.
- FINAL: hash_upd=1, then go to DONE.
- DONE: done=1, then go to IDLE. round clears to 0 on entering IDLE.
- Latency with no stalls: start accepted at cycle t gives LOAD at t+1, round 0 at t+2, last round at t+1+ROUNDS, hash_upd at t+2+ROUNDS, done at t+3+ROUNDS. That is done at t+67 in mode 0 and t+83 in mode 1.
- Each stall cycle adds exactly one cycle to this latency.
- start outside IDLE is ignored; there is no queuing. mode changes after acceptance have no effect.
- abort in any non-IDLE state: next state IDLE, round=0. No hash_upd and no done are produced. abort in IDLE blocks start.
- abort in the same cycle as a FINAL or DONE strobe: that strobe still fires; the next state is IDLE.
- rst mid-operation: immediate return to IDLE on the next edge. Strobes are suppressed.
- Counter arithmetic is CNT_W-bit unsigned. Wrap is unreachable because the round_last compare ends RUN.

Decomposition:
- Package sha_seq_pkg: state enum (IDLE/LOAD/RUN/FINAL/DONE), default round-count constants, MSG_WORDS.
- One sub-module, sha_round_cnt: CNT_W counter with clear/enable inputs and a terminal-count compare against a runtime limit. The FSM stays in sha_round_seq.

Test Plan:
- Mode 0, adv=1, start pulse at cycle 0 -> load_init@1, round 0..63 on cycles 2..65, round_last@65, hash_upd@66, done@67, busy high on cycles 1..67.
- Mode 1, same stimulus -> round_last at round 79 on cycle 81, done@83. msg_sel high exactly for rounds 0..15.
- Mode 0 with adv=0 for 3 cycles at round 20 -> round holds at 20, round_en low during the stall, done@70.
- abort asserted at round 30 -> IDLE next cycle, round=0, no hash_upd or done. A new start then completes normally.
- start held high for the entire run with mode toggled each cycle -> exactly one block per done; mode_q equals mode at acceptance; a new block starts from the next IDLE.
- rst asserted at round 40 -> all outputs 0 after the edge; no done issued.
